// File: rtl/shift_unit_seq_if.sv
// ============================================================================
// Module   : shift_unit_seq_if
// Brief    : start/done handshake and operand/result bus of the shift unit
// Revision : 1.0
// ============================================================================
`default_nettype none

interface shift_unit_seq_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] data_in;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] data_out;
    logic             busy;
    logic             done;

    modport master (
        output start, op, data_in, shamt,
        input  data_out, busy, done
    );

    modport slave (
        input  start, op, data_in, shamt,
        output data_out, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/shift_unit_seq.sv
// ============================================================================
// Module   : shift_unit_seq
// Brief    : multicycle shifter, one bit per clock; rotates under SHIFT_ROTATE_EN
// Revision : 1.0
// ============================================================================
`default_nettype none

module shift_unit_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  wire logic        clk,
    input  wire logic        reset,
    shift_unit_seq_if.slave  bus
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    localparam logic [2:0] c_OP_SLL = 3'b001;
    localparam logic [2:0] c_OP_SRL = 3'b010;
    localparam logic [2:0] c_OP_SRA = 3'b011;
`ifdef SHIFT_ROTATE_EN
    localparam logic [2:0] c_OP_ROR = 3'b100;
    localparam logic [2:0] c_OP_ROL = 3'b101;
`endif

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic [SHW-1:0]   count_q, count_d;
    logic [2:0]       op_q,    op_d;
    logic [WIDTH-1:0] w_step;

    // Pass and unsupported ops get a zero count so they finish straight away.
    function automatic logic op_shifts(input logic [2:0] op);
        case (op)
            c_OP_SLL, c_OP_SRL, c_OP_SRA: op_shifts = 1'b1;
`ifdef SHIFT_ROTATE_EN
            c_OP_ROR, c_OP_ROL:           op_shifts = 1'b1;
`endif
            default:                      op_shifts = 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= c_IDLE;
            data_q  <= '0;
            count_q <= '0;
            op_q    <= 3'b000;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            count_q <= count_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        w_step = data_q;
        case (op_q)
            c_OP_SLL: w_step = {data_q[WIDTH-2:0], 1'b0};
            c_OP_SRL: w_step = {1'b0, data_q[WIDTH-1:1]};
            c_OP_SRA: w_step = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
`ifdef SHIFT_ROTATE_EN
            c_OP_ROR: w_step = {data_q[0], data_q[WIDTH-1:1]};
            c_OP_ROL: w_step = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
`endif
            default:  w_step = data_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        count_d = count_q;
        op_d    = op_q;
        case (state_q)
            c_IDLE: begin
                if (bus.start) begin
                    state_d = c_SHIFT;
                    data_d  = bus.data_in;
                    op_d    = bus.op;
                    count_d = op_shifts(bus.op) ? bus.shamt : '0;
                end
            end
            c_SHIFT: begin
                if (count_q != '0) begin
                    data_d  = w_step;
                    count_d = count_q - SHW'(1);
                end else begin
                    state_d = c_DONE;
                end
            end
            c_DONE:  state_d = c_IDLE;
            default: state_d = c_IDLE;
        endcase
    end

    always_comb begin
        bus.busy     = (state_q == c_SHIFT) || (state_q == c_DONE);
        bus.done     = (state_q == c_DONE);
        bus.data_out = data_q;
    end

endmodule

`default_nettype wire
